mem_copy_dma: RTL and testbench

- MMIO-programmed XRAM-to-XRAM copy/fill engine behind the xiommu, the parametrised successor to the single-shot memory writer.
- Moves LEN bytes in chunks of at most BUF_DEPTH through an internal buffer.
- Adds three modes beyond that writer: plain copy, fill (constant byte, no reads) and write-only from the preloaded buffer.
- Adds abort, a sticky done flag and an interrupt; register base address and buffer depth are parameters.

---
 rtl/mem_copy_dma.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_copy_dma.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - MMIO-programmed XRAM copy/fill engine with chunk buffer
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   stb, wr, addr,      CPU register access; ack/in_addr_range flag hits on the
//   data_in, data_out,  16-byte register window at BASE_ADDR, data_out is
//   ack, in_addr_range  combinational read data
//   xram_*              XRAM master beat interface; one beat per xram_ack
//   busy, irq           engine active; done && irq_en

module mem_copy_dma #(
    parameter logic [15:0] BASE_ADDR = 16'hfa00,
    parameter int          BUF_DEPTH = 16,
    parameter int          BUF_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        ack,
    output logic        in_addr_range,
    output logic [15:0] xram_addr,
    output logic [7:0]  xram_data_out,
    input  logic [7:0]  xram_data_in,
    input  logic        xram_ack,
    output logic        xram_stb,
    output logic        xram_wr,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } state_t;

    localparam logic [1:0]      MODE_COPY = 2'b00;
    localparam logic [1:0]      MODE_FILL = 2'b01;
    localparam logic [15:0]     DEPTH16   = 16'(BUF_DEPTH);
    localparam logic [BUF_AW:0] DEPTH_C   = (BUF_AW + 1)'(BUF_DEPTH);
    localparam logic [BUF_AW:0] IDX_ONE   = (BUF_AW + 1)'(1);

    state_t            state, state_next;
    logic [15:0]       rd_addr, wr_addr, len, eff_len, eff_len_next;
    logic [15:0]       total, total_next;
    logic [BUF_AW:0]   idx, idx_next;
    logic [1:0]        mode;
    logic              irq_en;
    logic [7:0]        fill;
    logic              done, done_set;
    logic [7:0]        buf_mem [BUF_DEPTH];

    logic [3:0]        off;
    logic              cpu_wr, ctrl_wr, abort, start, cfg_wr, status_clr;
    logic              is_idle, beat, last;
    logic [15:0]       remaining, total_plus, start_len, base_addr;
    logic [BUF_AW:0]   chunk;

    // Register window decode. BASE_ADDR is 16-aligned, so the top 12 bits
    // identify the window and the compare never overflows near 16'hffff.
    assign off           = addr[3:0];
    assign in_addr_range = (addr[15:4] == BASE_ADDR[15:4]);
    assign ack           = stb && in_addr_range;
    assign cpu_wr        = ack && wr;
    assign ctrl_wr       = cpu_wr && (off == 4'h0);
    assign abort         = ctrl_wr && data_in[7];

    // Encoding 11 is unreachable; treating it as idle keeps the engine recoverable.
    assign is_idle    = (state != READ) && (state != WRITE);
    assign start      = ctrl_wr && data_in[0] && !data_in[7] && is_idle;
    assign cfg_wr     = cpu_wr && is_idle;
    assign status_clr = cpu_wr && (off == 4'hA) && data_in[0];

    assign xram_stb = (state == READ) || (state == WRITE);
    assign xram_wr  = (state == WRITE);
    assign beat     = xram_stb && xram_ack;
    assign busy     = (state != IDLE);
    assign irq      = done && irq_en;

    // Current chunk is the lesser of the buffer depth and the bytes left.
    assign remaining  = eff_len - total;
    assign chunk      = (remaining >= DEPTH16) ? DEPTH_C : remaining[BUF_AW:0];
    assign last       = ((idx + IDX_ONE) == chunk);
    assign total_plus = total + 16'(chunk);

    // Write-only replays the buffer once, so its length cannot exceed one chunk.
    assign start_len = ((mode == MODE_COPY) || (mode == MODE_FILL) || (len <= DEPTH16))
                       ? len : DEPTH16;

    assign base_addr = (state == WRITE) ? wr_addr : rd_addr;
    assign xram_addr = xram_stb ? (base_addr + total + 16'(idx)) : 16'h0000;

    always_comb begin
        xram_data_out = 8'h00;
        if (state == WRITE) begin
            xram_data_out = (mode == MODE_FILL) ? fill : buf_mem[idx[BUF_AW-1:0]];
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (in_addr_range) begin
            case (off)
                4'h1:    data_out = {5'b0, done, state};
                4'h2:    data_out = rd_addr[7:0];
                4'h3:    data_out = rd_addr[15:8];
                4'h4:    data_out = wr_addr[7:0];
                4'h5:    data_out = wr_addr[15:8];
                4'h6:    data_out = len[7:0];
                4'h7:    data_out = len[15:8];
                4'h8:    data_out = {5'b0, irq_en, mode};
                4'h9:    data_out = fill;
                4'hA:    data_out = {7'b0, done};
                default: data_out = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        total_next   = total;
        eff_len_next = eff_len;
        done_set     = 1'b0;
        case (state)
            READ: begin
                if (beat) begin
                    if (last) begin
                        idx_next   = '0;
                        state_next = WRITE;
                    end else begin
                        idx_next = idx + IDX_ONE;
                    end
                end
            end
            WRITE: begin
                if (beat) begin
                    if (last) begin
                        idx_next   = '0;
                        total_next = total_plus;
                        if (total_plus == eff_len) begin
                            state_next = IDLE;
                            done_set   = 1'b1;
                        end else if (mode == MODE_COPY) begin
                            state_next = READ;
                        end else begin
                            state_next = WRITE;
                        end
                    end else begin
                        idx_next = idx + IDX_ONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    idx_next     = '0;
                    total_next   = 16'h0000;
                    eff_len_next = start_len;
                    if (start_len == 16'h0000) begin
                        state_next = IDLE;
                        done_set   = 1'b1;
                    end else if (mode == MODE_COPY) begin
                        state_next = READ;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
        endcase
        // Abort overrides everything, including a beat completing this cycle.
        if (abort) begin
            state_next   = IDLE;
            idx_next     = idx;
            total_next   = total;
            eff_len_next = eff_len;
            done_set     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            total   <= 16'h0000;
            eff_len <= 16'h0000;
            done    <= 1'b0;
            rd_addr <= 16'h0000;
            wr_addr <= 16'h0000;
            len     <= 16'h0000;
            mode    <= 2'b00;
            irq_en  <= 1'b0;
            fill    <= 8'h00;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            total   <= total_next;
            eff_len <= eff_len_next;
            if (done_set) begin
                done <= 1'b1;
            end else if (status_clr) begin
                done <= 1'b0;
            end
            if (cfg_wr) begin
                case (off)
                    4'h2: rd_addr[7:0]  <= data_in;
                    4'h3: rd_addr[15:8] <= data_in;
                    4'h4: wr_addr[7:0]  <= data_in;
                    4'h5: wr_addr[15:8] <= data_in;
                    4'h6: len[7:0]      <= data_in;
                    4'h7: len[15:8]     <= data_in;
                    4'h8: begin
                        mode   <= data_in[1:0];
                        irq_en <= data_in[2];
                    end
                    4'h9: fill <= data_in;
                    default: ;
                endcase
            end
        end
    end

    // Chunk buffer has no reset; its contents persist for write-only mode.
    always_ff @(posedge clk) begin
        if ((state == READ) && beat && !abort) begin
            buf_mem[idx[BUF_AW-1:0]] <= xram_data_in;
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - self-checking bench for mem_copy_dma

module tb_mem_copy_dma;

    localparam logic [15:0] B = 16'hfa00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stb = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        ack;
    logic        in_addr_range;
    logic [15:0] xram_addr;
    logic [7:0]  xram_data_out;
    logic [7:0]  xram_data_in = 8'h00;
    logic        xram_ack = 1'b0;
    logic        xram_stb;
    logic        xram_wr;
    logic        busy;
    logic        irq;

    mem_copy_dma #(.BASE_ADDR(16'hfa00), .BUF_DEPTH(16), .BUF_AW(4)) dut (
        .clk(clk), .rst(rst), .stb(stb), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack),
        .in_addr_range(in_addr_range), .xram_addr(xram_addr),
        .xram_data_out(xram_data_out), .xram_data_in(xram_data_in),
        .xram_ack(xram_ack), .xram_stb(xram_stb), .xram_wr(xram_wr),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
    } beat_t;

    typedef struct {
        logic        do_wr;
        logic [15:0] wa;
        logic [7:0]  wd;
        logic [15:0] ra;
        logic [7:0]  exp_d;
        logic        exp_r;
    } vec_t;

    logic [7:0] mem [65536];
    beat_t      log_q[$];
    int         ack_mode = 0;
    int         ack_budget = 0;
    bit         stb_seen = 1'b0;
    int         tests = 0;
    int         fails = 0;

    // XRAM slave model: acks are decided on the falling edge so the DUT
    // samples them on the next rising edge together with stable data.
    always @(negedge clk) begin
        if (!rst) begin
            xram_ack = 1'b0;
        end else begin
            logic a;
            case (ack_mode)
                1:       a = 1'b1;
                2:       a = ($urandom_range(0, 3) != 0);
                3:       a = (ack_budget > 0);
                default: a = 1'b0;
            endcase
            if (xram_stb) begin
                stb_seen = 1'b1;
                if (a) begin
                    if (ack_mode == 3) ack_budget--;
                    if (xram_wr) begin
                        mem[xram_addr] = xram_data_out;
                        log_q.push_back({1'b1, xram_addr, xram_data_out});
                    end else begin
                        xram_data_in = mem[xram_addr];
                        log_q.push_back({1'b0, xram_addr, mem[xram_addr]});
                    end
                end
            end else if (ack_mode != 2) begin
                a = 1'b0;
            end
            xram_ack = a;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; data_in = d; wr = 1'b1; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0; wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d,
                            output logic r, output logic k);
        @(negedge clk);
        addr = a; wr = 1'b0; stb = 1'b1;
        #1;
        d = data_out; r = in_addr_range; k = ack;
        stb = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic r, k;
        cpu_read(a, d, r, k);
        check(name, d, exp);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle timeout"}, busy, 1'b0);
    endtask

    task automatic setup(input logic [15:0] rd, input logic [15:0] wa, input logic [15:0] ln,
                         input logic [7:0] md, input logic [7:0] fl);
        cpu_write(B + 16'h2, rd[7:0]);  cpu_write(B + 16'h3, rd[15:8]);
        cpu_write(B + 16'h4, wa[7:0]);  cpu_write(B + 16'h5, wa[15:8]);
        cpu_write(B + 16'h6, ln[7:0]);  cpu_write(B + 16'h7, ln[15:8]);
        cpu_write(B + 16'h8, md);       cpu_write(B + 16'h9, fl);
    endtask

    function automatic logic [7:0] src40(input int j);
        return 8'(j * 7 + 3);
    endfunction

    vec_t vecs[10];

    initial begin
        logic [7:0] d;
        logic r, k;
        int errs, rc, wc;
        logic exp_w;

        vecs[0] = '{1'b1, B + 16'h2, 8'h34, B + 16'h2, 8'h34, 1'b1};
        vecs[1] = '{1'b1, B + 16'h3, 8'h12, B + 16'h3, 8'h12, 1'b1};
        vecs[2] = '{1'b1, B + 16'h8, 8'h07, B + 16'h8, 8'h07, 1'b1};
        vecs[3] = '{1'b1, B + 16'h9, 8'h5a, B + 16'h9, 8'h5a, 1'b1};
        vecs[4] = '{1'b1, B + 16'h5, 8'hab, B + 16'h5, 8'hab, 1'b1};
        vecs[5] = '{1'b1, B + 16'hb, 8'hff, B + 16'hb, 8'h00, 1'b1};
        vecs[6] = '{1'b1, B + 16'h1, 8'hff, B + 16'h1, 8'h00, 1'b1};
        vecs[7] = '{1'b1, B + 16'hf, 8'h3c, B + 16'hf, 8'h00, 1'b1};
        vecs[8] = '{1'b0, 16'h0000, 8'h00, 16'hfa10, 8'h00, 1'b0};
        vecs[9] = '{1'b0, 16'h0000, 8'h00, 16'hf9ff, 8'h00, 1'b0};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 5; i++)  mem[16'h0100 + i] = 8'h10 + 8'(i);
        for (int i = 0; i < 40; i++) mem[16'h0300 + i] = src40(i);
        mem[16'h0610] = 8'hee;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset busy", busy, 1'b0);
        check("reset stb", xram_stb, 1'b0);
        check("reset irq", irq, 1'b0);

        for (int i = 0; i < 16; i++) begin
            cpu_read(B + 16'(i), d, r, k);
            check($sformatf("reset read off %0h", i), d, 8'h00);
            check($sformatf("range off %0h", i), r, 1'b1);
            check($sformatf("ack off %0h", i), k, 1'b1);
        end
        #1;
        check("ack without stb", ack, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) cpu_write(vecs[i].wa, vecs[i].wd);
            cpu_read(vecs[i].ra, d, r, k);
            check($sformatf("vec%0d data", i), d, vecs[i].exp_d);
            check($sformatf("vec%0d range", i), r, vecs[i].exp_r);
            check($sformatf("vec%0d ack", i), k, vecs[i].exp_r);
        end

        // Copy LEN=5, ack every cycle, irq enabled.
        ack_mode = 1;
        setup(16'h0100, 16'h0200, 16'd5, 8'h04, 8'h00);
        log_q.delete();
        cpu_write(B, 8'h01);
        wait_idle("copy5", 200);
        check("copy5 beats", log_q.size(), 10);
        errs = 0;
        for (int i = 0; i < 10 && i < log_q.size(); i++) begin
            if (i < 5) begin
                if (log_q[i] !== {1'b0, 16'h0100 + 16'(i), 8'h10 + 8'(i)}) errs++;
            end else begin
                if (log_q[i] !== {1'b1, 16'h0200 + 16'(i - 5), 8'h10 + 8'(i - 5)}) errs++;
            end
        end
        check("copy5 beat contents", errs, 0);
        check("copy5 irq", irq, 1'b1);
        read_check("copy5 state", B + 16'h1, 8'h04);
        cpu_write(B + 16'ha, 8'h01);
        check("copy5 irq cleared", irq, 1'b0);

        // Copy LEN=40 with random ack stalls.
        ack_mode = 2;
        setup(16'h0300, 16'h0400, 16'd40, 8'h00, 8'h00);
        log_q.delete();
        cpu_write(B, 8'h01);
        wait_idle("copy40", 3000);
        check("copy40 beats", log_q.size(), 80);
        errs = 0; rc = 0; wc = 0;
        for (int kk = 0; kk < log_q.size(); kk++) begin
            exp_w = !(kk < 16 || (kk >= 32 && kk < 48) || (kk >= 64 && kk < 72));
            if (log_q[kk].w !== exp_w) errs++;
            else if (exp_w) begin
                if (log_q[kk].a !== 16'h0400 + 16'(wc) || log_q[kk].d !== src40(wc)) errs++;
                wc++;
            end else begin
                if (log_q[kk].a !== 16'h0300 + 16'(rc) || log_q[kk].d !== src40(rc)) errs++;
                rc++;
            end
        end
        check("copy40 beat order", errs, 0);
        errs = 0;
        for (int i = 0; i < 40; i++) if (mem[16'h0400 + i] !== src40(i)) errs++;
        check("copy40 dest bytes", errs, 0);
        read_check("copy40 state", B + 16'h1, 8'h04);
        check("copy40 irq off", irq, 1'b0);

        // Write-only: LEN=20 clamps to 16, replays the buffer left by copy40.
        ack_mode = 1;
        cpu_write(B + 16'ha, 8'h01);
        setup(16'h0000, 16'h0600, 16'd20, 8'h02, 8'h00);
        log_q.delete();
        cpu_write(B, 8'h01);
        wait_idle("wronly", 200);
        check("wronly beats", log_q.size(), 16);
        errs = 0;
        for (int i = 0; i < 16; i++)
            if (mem[16'h0600 + i] !== src40(i < 8 ? 32 + i : 16 + i)) errs++;
        check("wronly bytes", errs, 0);
        check("wronly clamp", mem[16'h0610], 8'hee);

        // Fill with address wrap.
        cpu_write(B + 16'ha, 8'h01);
        setup(16'h0000, 16'hfffe, 16'd4, 8'h01, 8'ha5);
        log_q.delete();
        cpu_write(B, 8'h01);
        wait_idle("fill", 200);
        check("fill beats", log_q.size(), 4);
        errs = 0;
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            if (log_q[i] !== {1'b1, 16'hfffe + 16'(i), 8'ha5}) errs++;
        check("fill wrap contents", errs, 0);
        read_check("fill state", B + 16'h1, 8'h04);

        // Abort after 3 read acks of LEN=10.
        cpu_write(B + 16'ha, 8'h01);
        setup(16'h0500, 16'h0700, 16'd10, 8'h00, 8'h00);
        log_q.delete();
        ack_budget = 3;
        ack_mode = 3;
        cpu_write(B, 8'h01);
        for (int n = 0; n < 50 && log_q.size() < 3; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("abort read acks", log_q.size(), 3);
        read_check("abort pre state", B + 16'h1, 8'h01);
        cpu_write(B, 8'h01);
        read_check("start while busy", B + 16'h1, 8'h01);
        check("start while busy addr", xram_addr, 16'h0503);
        cpu_write(B + 16'h2, 8'h77);
        read_check("busy cfg write ignored", B + 16'h2, 8'h00);
        cpu_write(B, 8'h80);
        check("abort busy", busy, 1'b0);
        check("abort stb", xram_stb, 1'b0);
        read_check("abort state no done", B + 16'h1, 8'h00);
        cpu_write(B + 16'h2, 8'h77);
        read_check("post abort cfg write", B + 16'h2, 8'h77);

        // LEN=0 start.
        ack_mode = 1;
        cpu_write(B + 16'h6, 8'h00);
        stb_seen = 1'b0;
        cpu_write(B, 8'h01);
        read_check("len0 done", B + 16'h1, 8'h04);
        repeat (3) @(negedge clk);
        check("len0 no stb", stb_seen, 1'b0);
        cpu_write(B + 16'ha, 8'h01);
        read_check("status clear", B + 16'h1, 8'h00);

        // Asynchronous reset during WRITE.
        ack_mode = 0;
        setup(16'h0000, 16'h0800, 16'd20, 8'h01, 8'h11);
        cpu_write(B, 8'h01);
        check("pre reset stb", xram_stb, 1'b1);
        read_check("pre reset state", B + 16'h1, 8'h02);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async reset stb", xram_stb, 1'b0);
        check("async reset busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        read_check("post reset len", B + 16'h6, 8'h00);
        read_check("post reset state", B + 16'h1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
